led_scanner: RTL and testbench

//  Parametrised "Knight Rider" LED scanner for the DE-series LED bank.
//  - Moves a lit head across NUM_LEDS outputs at a programmable step rate.
//  - Two modes: bounce (sweep back and forth) and wrap (circular).
//  - Generates the step rate with a clock-enable prescaler, not a derived clock.
//  - Sits directly between CLOCK_50 and the LEDR pins in the top level.

---
 rtl/led_scanner_if.sv | 32 +++
 rtl/led_scanner.sv | 129 ++++++++++++
 tb/tb_led_scanner.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_scanner_if.sv
// Control and status bundle of the LED scanner: run/mode controls in,
// LED drive plus head position, direction and step pulse out.
interface led_scanner_if #(
    parameter int NUM_LEDS = 10
) ();
    localparam int POS_W = $clog2(NUM_LEDS);

    logic                enable;
    logic                mode;
    logic [NUM_LEDS-1:0] LEDR;
    logic [POS_W-1:0]    pos;
    logic                dir_down;
    logic                step;

    modport master (
        output enable,
        output mode,
        input  LEDR,
        input  pos,
        input  dir_down,
        input  step
    );

    modport slave (
        input  enable,
        input  mode,
        output LEDR,
        output pos,
        output dir_down,
        output step
    );
endinterface

// File: rtl/led_scanner.sv
// Knight Rider LED scanner: a lit head that bounces or wraps at a prescaled step rate.
// Optional fading trail of previous positions when LED_SCANNER_TRAIL_EN is defined.
module led_scanner #(
    parameter int NUM_LEDS     = 10,
    parameter int PRESCALE_MAX = 16384,
    parameter int TRAIL_LEN    = 2
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    led_scanner_if.slave  bus
);
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam int CNT_W = (PRESCALE_MAX > 1) ? $clog2(PRESCALE_MAX) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE_MAX - 1);

    if (NUM_LEDS < 2 || PRESCALE_MAX < 1 || TRAIL_LEN < 1 || TRAIL_LEN > NUM_LEDS - 1) begin : g_bad_param
        $error("led_scanner: parameter out of range");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                step_q, step_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [NUM_LEDS-1:0] ledr_q, ledr_d;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return NUM_LEDS'(1) << p;
    endfunction

    // Prescaler holds its count while disabled so a resume finishes the partial period.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        pos_d  = pos_q;
        dir_d  = dir_q;
        if (bus.enable) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (step_d) begin
            if (bus.mode) begin
                dir_d = 1'b0;
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
            end else if (!dir_q) begin
                if (pos_q == POS_MAX) begin
                    pos_d = POS_MAX - POS_W'(1);
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d = POS_W'(1);
                    dir_d = 1'b0;
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end
        end
    end

`ifdef LED_SCANNER_TRAIL_EN
    logic [POS_W-1:0]     trail_pos_q [TRAIL_LEN];
    logic [POS_W-1:0]     trail_pos_d [TRAIL_LEN];
    logic [TRAIL_LEN-1:0] trail_vld_q, trail_vld_d;

    // Newest trail entry is index 0; the head it just left is pushed on every step.
    always_comb begin
        trail_pos_d = trail_pos_q;
        trail_vld_d = trail_vld_q;
        if (step_d) begin
            for (int i = TRAIL_LEN - 1; i > 0; i--) begin
                trail_pos_d[i] = trail_pos_q[i-1];
                trail_vld_d[i] = trail_vld_q[i-1];
            end
            trail_pos_d[0] = pos_q;
            trail_vld_d[0] = 1'b1;
        end
        ledr_d = onehot(pos_d);
        for (int i = 0; i < TRAIL_LEN; i++) begin
            if (trail_vld_d[i]) begin
                ledr_d = ledr_d | onehot(trail_pos_d[i]);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            trail_vld_q <= '0;
        end else begin
            trail_vld_q <= trail_vld_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        trail_pos_q <= trail_pos_d;
    end
`else
    always_comb begin
        ledr_d = onehot(pos_d);
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            ledr_q <= NUM_LEDS'(1);
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ledr_q <= ledr_d;
        end
    end

    assign bus.LEDR     = ledr_q;
    assign bus.pos      = pos_q;
    assign bus.dir_down = dir_q;
    assign bus.step     = step_q;
endmodule

// File: tb/tb_led_scanner.sv
// Self-checking bench for led_scanner: a 10-LED/prescale-4 instance and a
// 5-LED/prescale-1 instance, both compared every cycle against a behavioural model.
module tb_led_scanner;
    localparam int NA = 10;
    localparam int PA = 4;
    localparam int NB = 5;
    localparam int PB = 1;
    localparam int TL = 2;

    logic CLOCK_50 = 1'b0;
    logic RESET_N;
    always #5 CLOCK_50 = ~CLOCK_50;

    led_scanner_if #(.NUM_LEDS(NA)) ifa ();
    led_scanner_if #(.NUM_LEDS(NB)) ifb ();

    led_scanner #(.NUM_LEDS(NA), .PRESCALE_MAX(PA), .TRAIL_LEN(TL)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (ifa.slave)
    );

    led_scanner #(.NUM_LEDS(NB), .PRESCALE_MAX(PB), .TRAIL_LEN(TL)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (ifb.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model, index 0 = instance a, 1 = instance b.
    int mp [2];
    bit md [2];
    bit ms [2];
    int ec [2];
    int hist [2][TL];
    int hv [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task upd(input int k);
        int n, pm, t;
        bit en, wrap;
        n    = (k == 0) ? NA : NB;
        pm   = (k == 0) ? PA : PB;
        en   = (k == 0) ? ifa.enable : ifb.enable;
        wrap = (k == 0) ? ifa.mode : ifb.mode;
        if (!RESET_N) begin
            mp[k] = 0; md[k] = 0; ms[k] = 0; ec[k] = 0; hv[k] = 0;
            return;
        end
        ms[k] = 0;
        if (en) begin
            ec[k]++;
            if (ec[k] % pm == 0) begin
                ms[k] = 1;
                for (int i = TL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = mp[k];
                if (hv[k] < TL) hv[k]++;
                if (wrap) begin
                    md[k] = 0;
                    mp[k] = (mp[k] + 1) % n;
                end else begin
                    t = md[k] ? mp[k] - 1 : mp[k] + 1;
                    if (t > n - 1) begin
                        t = n - 2; md[k] = 1;
                    end else if (t < 0) begin
                        t = 1; md[k] = 0;
                    end
                    mp[k] = t;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_led(input int k);
        logic [31:0] v;
        v = 32'd1 << mp[k];
`ifdef LED_SCANNER_TRAIL_EN
        for (int i = 0; i < hv[k]; i++) v = v | (32'd1 << hist[k][i]);
`endif
        return v;
    endfunction

    // One clock: advance the model on the edge, compare both DUTs just after it.
    task cyc();
        @(posedge CLOCK_50);
        upd(0);
        upd(1);
        #1;
        chk("ledr_a", 32'(ifa.LEDR), exp_led(0));
        chk("pos_a",  32'(ifa.pos), 32'(mp[0]));
        chk("dir_a",  32'(ifa.dir_down), 32'(md[0]));
        chk("step_a", 32'(ifa.step), 32'(ms[0]));
        chk("ledr_b", 32'(ifb.LEDR), exp_led(1));
        chk("pos_b",  32'(ifb.pos), 32'(mp[1]));
        chk("dir_b",  32'(ifb.dir_down), 32'(md[1]));
        chk("step_b", 32'(ifb.step), 32'(ms[1]));
    endtask

    task run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task do_reset();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1;
    endtask

    initial begin
        int cnt;
        bit seen;
        int seq [10];
        seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        RESET_N    = 1'b0;
        ifa.enable = 1'b0; ifa.mode = 1'b0;
        ifb.enable = 1'b0; ifb.mode = 1'b0;
        run(2);
        chk("reset_ledr", 32'(ifa.LEDR), 32'h1);
        chk("reset_pos",  32'(ifa.pos), 32'd0);
        RESET_N = 1'b1;

        // Full bounce sweep: 18 steps, 4 cycles apart, back at position 0.
        ifa.enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 * 18; i++) begin
            cyc();
            if (ifa.step === 1'b1) cnt++;
        end
        chk("sweep_steps", 32'(cnt), 32'd18);
        chk("sweep_end_pos", 32'(ifa.pos), 32'd0);

        // Wrap mode across the top end.
        do_reset();
        ifa.mode = 1'b1;
        run(4 * 12);
        chk("wrap_pos", 32'(ifa.pos), 32'd2);
        chk("wrap_dir", 32'(ifa.dir_down), 32'd0);

        // Freeze at position 5 with a partial prescale count, then resume.
        do_reset();
        ifa.mode = 1'b0;
        run(22);
        ifa.enable = 1'b0;
        run(20);
        chk("hold_pos", 32'(ifa.pos), 32'd5);
        chk("hold_step", 32'(ifa.step), 32'd0);
`ifndef LED_SCANNER_TRAIL_EN
        chk("hold_ledr", 32'(ifa.LEDR), 32'h020);
`endif
        ifa.enable = 1'b1;
        cnt = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            cnt++;
            if (ifa.step === 1'b1) seen = 1;
        end
        chk("resume_seen", 32'(seen), 32'd1);
        chk("resume_latency", 32'(cnt), 32'd2);

        // Mode switch while sweeping down, then a one-edge reset.
        do_reset();
        ifa.mode = 1'b0;
        run(44);
        chk("down_pos", 32'(ifa.pos), 32'd7);
        chk("down_dir", 32'(ifa.dir_down), 32'd1);
        ifa.mode = 1'b1;
        run(4);
        chk("switch_pos", 32'(ifa.pos), 32'd8);
        chk("switch_dir", 32'(ifa.dir_down), 32'd0);
        RESET_N = 1'b0;
        cyc();
        chk("rst_ledr", 32'(ifa.LEDR), 32'h1);
        chk("rst_pos", 32'(ifa.pos), 32'd0);
        chk("rst_step", 32'(ifa.step), 32'd0);
        RESET_N = 1'b1;
        ifa.mode = 1'b0;

`ifdef LED_SCANNER_TRAIL_EN
        do_reset();
        run(12);
        chk("trail_3", 32'(ifa.LEDR), 32'h00E);
        run(24);
        chk("trail_top", 32'(ifa.LEDR), 32'h380);
        run(4);
        chk("trail_after_top", 32'(ifa.LEDR), 32'h300);
`endif

        // Small odd-sized instance stepping every cycle.
        ifb.enable = 1'b1;
        ifb.mode   = 1'b0;
        do_reset();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1;
        chk("b_seq_0", 32'(ifb.pos), 32'(seq[0]));
        for (int i = 1; i < 10; i++) begin
            cyc();
            chk("b_seq", 32'(ifb.pos), 32'(seq[i]));
        end

        // Randomized enable/mode/reset traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            ifa.enable = ($urandom_range(0, 7) != 0);
            ifb.enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) ifa.mode = ~ifa.mode;
            if ($urandom_range(0, 7) == 0)  ifb.mode = ~ifb.mode;
            RESET_N = ($urandom_range(0, 99) != 0);
            cyc();
            chk("b_pos_range", 32'(ifb.pos <= 3'd4), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
